// File: rtl/midi_rx_pkg.sv
// Shared constants, state encodings and byte classification for the MIDI receiver.
package midi_rx_pkg;

    localparam int         MIDI_BAUD        = 31250;
    localparam logic [3:0] MIDI_ST_NOTE_OFF = 4'h8;
    localparam logic [3:0] MIDI_ST_NOTE_ON  = 4'h9;
    localparam logic [7:0] MIDI_RT_MIN      = 8'hF8;
    localparam logic [7:0] MIDI_SYS_MIN     = 8'hF0;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_e;

    typedef enum logic [2:0] {
        BC_REALTIME,
        BC_SYSTEM,
        BC_NOTE_STATUS,
        BC_OTHER_STATUS,
        BC_DATA
    } byte_class_e;

    // Sort a received byte into the categories the message filter cares about.
    function automatic byte_class_e classify(input logic [7:0] b);
        if (b >= MIDI_RT_MIN) begin
            return BC_REALTIME;
        end else if (b >= MIDI_SYS_MIN) begin
            return BC_SYSTEM;
        end else if (b[7:4] == MIDI_ST_NOTE_OFF || b[7:4] == MIDI_ST_NOTE_ON) begin
            return BC_NOTE_STATUS;
        end else if (b[7]) begin
            return BC_OTHER_STATUS;
        end else begin
            return BC_DATA;
        end
    endfunction

endpackage

// File: rtl/midi_uart_rx.sv
// MIDI UART deserialiser: input synchroniser plus start/data/stop/break FSM.
// Emits a one-cycle byteValid_o with the byte, or frameErr_o on a low stop bit.
module midi_uart_rx
    import midi_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 32
) (
    input  logic       clk_i,
    input  logic       nrst_i,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byteValid_o,
    output logic       frameErr_o
);

    localparam int             CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);

    logic            rx_meta_q;
    logic            rx_s_q;
    rx_state_e       state_q,     state_d;
    logic [CW-1:0]   baud_q,      baud_d;
    logic [2:0]      bit_q,       bit_d;
    logic [7:0]      shift_q,     shift_d;
    logic            valid_q,     valid_d;
    logic            frame_err_q, frame_err_d;

    // Two-flop synchroniser; idles high so reset does not look like a start bit.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
        end
    end

    // RX FSM state, counters, shift register and output strobes.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q     <= RX_IDLE;
            baud_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Next-state logic: mid-bit sampling, LSB first, stop-bit validation.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d     = state_q;
        baud_d      = baud_q + 1'b1;
        bit_d       = bit_q;
        shift_d     = shift_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (!rx_s_q) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (baud_q == HALF_CNT) begin
                    baud_d  = '0;
                    state_d = rx_s_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (baud_q == LAST_CNT) begin
                    baud_d  = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (baud_q == LAST_CNT) begin
                    baud_d = '0;
                    if (rx_s_q) begin
                        valid_d = 1'b1;
                        state_d = RX_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = RX_BREAK;
                    end
                end
            end
            RX_BREAK: begin
                baud_d = '0;
                if (rx_s_q) begin
                    state_d = RX_IDLE;
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    assign byte_o      = shift_q;
    assign byteValid_o = valid_q;
    assign frameErr_o  = frame_err_q;

endmodule

// File: rtl/midi_rx.sv
// MIDI front end: UART receive, running-status expansion and Note-On/Off filter.
// Completed note messages leave as 3-cycle bursts: status, note, velocity.
module midi_rx
    import midi_rx_pkg::*;
#(
    parameter int CLK_HZ = 12_000_000,
    parameter int BAUD   = MIDI_BAUD
) (
    input  logic       clk_i,
    input  logic       nrst_i,
    input  logic       rx_i,
    output logic       midiByteValid_o,
    output logic [7:0] midiByte_o,
    output logic       frameErr_o
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_frame_err;

    logic [7:0] run_st_q,     run_st_d;
    logic       data_cnt_q,   data_cnt_d;
    logic [7:0] note_q,       note_d;
    logic [1:0] burst_cnt_q,  burst_cnt_d;
    logic [7:0] burst_st_q,   burst_st_d;
    logic [7:0] burst_note_q, burst_note_d;
    logic [7:0] burst_vel_q,  burst_vel_d;

    midi_uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clk_i       (clk_i),
        .nrst_i      (nrst_i),
        .rx_i        (rx_i),
        .byte_o      (rx_byte),
        .byteValid_o (rx_valid),
        .frameErr_o  (rx_frame_err)
    );

    // Running status, partial message and burst snapshot registers.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            run_st_q     <= '0;
            data_cnt_q   <= 1'b0;
            note_q       <= '0;
            burst_cnt_q  <= '0;
            burst_st_q   <= '0;
            burst_note_q <= '0;
            burst_vel_q  <= '0;
        end else begin
            run_st_q     <= run_st_d;
            data_cnt_q   <= data_cnt_d;
            note_q       <= note_d;
            burst_cnt_q  <= burst_cnt_d;
            burst_st_q   <= burst_st_d;
            burst_note_q <= burst_note_d;
            burst_vel_q  <= burst_vel_d;
        end
    end

    // Message filter: track running status, collect note/velocity, launch bursts.
    always_comb begin
        run_st_d     = run_st_q;
        data_cnt_d   = data_cnt_q;
        note_d       = note_q;
        burst_st_d   = burst_st_q;
        burst_note_d = burst_note_q;
        burst_vel_d  = burst_vel_q;
        burst_cnt_d  = burst_cnt_q;

        if (burst_cnt_q != 2'd0) begin
            burst_cnt_d = (burst_cnt_q == 2'd3) ? 2'd0 : burst_cnt_q + 2'd1;
        end

        // A broken byte abandons the half-built message but keeps running status.
        if (rx_frame_err) begin
            data_cnt_d = 1'b0;
        end

        if (rx_valid) begin
            unique case (classify(rx_byte))
                BC_REALTIME: begin
                    // Realtime bytes may interleave a message; leave state alone.
                end
                BC_NOTE_STATUS: begin
                    run_st_d   = rx_byte;
                    data_cnt_d = 1'b0;
                end
                BC_SYSTEM, BC_OTHER_STATUS: begin
                    run_st_d   = '0;
                    data_cnt_d = 1'b0;
                end
                BC_DATA: begin
                    if (run_st_q != 8'h00) begin
                        if (!data_cnt_q) begin
                            note_d     = rx_byte;
                            data_cnt_d = 1'b1;
                        end else begin
                            data_cnt_d   = 1'b0;
                            burst_cnt_d  = 2'd1;
                            burst_st_d   = run_st_q;
                            burst_note_d = note_q;
                            burst_vel_d  = rx_byte;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Burst output mux; the byte bus reads zero outside a burst.
    always_comb begin
        midiByte_o = 8'h00;
        unique case (burst_cnt_q)
            2'd1:    midiByte_o = burst_st_q;
            2'd2:    midiByte_o = burst_note_q;
            2'd3:    midiByte_o = burst_vel_q;
            default: midiByte_o = 8'h00;
        endcase
    end

    assign midiByteValid_o = (burst_cnt_q != 2'd0);
    assign frameErr_o      = rx_frame_err;

endmodule

// File: tb/tb_midi_rx.sv
// Self-checking bench for midi_rx at 1 MHz / 31250 baud (32 clocks per bit).
// Tasks drive serial frames and push expected burst bytes; a negedge monitor
// pops and compares each strobe as the DUT produces it.
module tb_midi_rx;

    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 31250;
    localparam int CPB    = 32;
    localparam int LAT    = 308;  // frame start to first burst byte
    localparam int TOL    = 4;

    logic       clk_i  = 1'b0;
    logic       nrst_i = 1'b0;
    logic       rx_i   = 1'b1;
    logic       midiByteValid_o;
    logic [7:0] midiByte_o;
    logic       frameErr_o;

    midi_rx #(
        .CLK_HZ(CLK_HZ),
        .BAUD  (BAUD)
    ) dut (
        .clk_i           (clk_i),
        .nrst_i          (nrst_i),
        .rx_i            (rx_i),
        .midiByteValid_o (midiByteValid_o),
        .midiByte_o      (midiByte_o),
        .frameErr_o      (frameErr_o)
    );

    always #5 clk_i = ~clk_i;

    int cycle = 0;
    always @(posedge clk_i) cycle++;

    typedef struct {
        logic [7:0] b;
        int         cyc;
        bit         first;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks      = 0;
    int   errors      = 0;
    int   fe_count    = 0;
    int   last_strobe = -10;

    // Scoreboard monitor: every strobe must match the next expected byte and timing.
    always @(negedge clk_i) begin
        if (frameErr_o) fe_count++;
        if (midiByteValid_o) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: got byte %02h at cycle %0d, required no strobe",
                         midiByte_o, cycle);
            end else begin
                mon_e = exp_q.pop_front();
                if (midiByte_o !== mon_e.b) begin
                    errors++;
                    $display("FAIL burst_byte: got %02h, required %02h (cycle %0d)",
                             midiByte_o, mon_e.b, cycle);
                end
                checks++;
                if (mon_e.first) begin
                    if (cycle < mon_e.cyc - TOL || cycle > mon_e.cyc + TOL) begin
                        errors++;
                        $display("FAIL burst_latency: first byte at cycle %0d, required %0d +/- %0d",
                                 cycle, mon_e.cyc, TOL);
                    end
                end else if (cycle != last_strobe + 1) begin
                    errors++;
                    $display("FAIL burst_gap: byte at cycle %0d, required cycle %0d",
                             cycle, last_strobe + 1);
                end
            end
            last_strobe = cycle;
        end
    end

    // Drive one UART frame; optionally expect the first push_n bytes of a burst.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int push_n,
                              input logic [7:0] st, input logic [7:0] note);
        int   start;
        exp_t e;
        @(negedge clk_i);
        start = cycle;
        for (int k = 0; k < push_n; k++) begin
            e.b     = (k == 0) ? st : (k == 1) ? note : b;
            e.cyc   = start + LAT + k;
            e.first = (k == 0);
            exp_q.push_back(e);
        end
        rx_i = 1'b0;
        repeat (CPB) @(negedge clk_i);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            repeat (CPB) @(negedge clk_i);
        end
        rx_i = stop_ok;
        repeat (CPB) @(negedge clk_i);
        if (stop_ok) rx_i = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b1, 0, 8'h00, 8'h00);
    endtask

    task automatic send_note(input logic [7:0] st, input logic [7:0] note, input logic [7:0] vel);
        send_byte(st);
        send_byte(note);
        send_frame(vel, 1'b1, 3, st, note);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic test_reset();
        nrst_i = 1'b0;
        rx_i   = 1'b1;
        idle(4);
        checks++;
        if (midiByteValid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b, required 0", midiByteValid_o);
        end
        checks++;
        if (midiByte_o !== 8'h00) begin
            errors++;
            $display("FAIL reset_byte: got %02h, required 00", midiByte_o);
        end
        checks++;
        if (frameErr_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_frameerr: got %b, required 0", frameErr_o);
        end
        nrst_i = 1'b1;
        idle(10);
    endtask

    task automatic test_note_on();
        int fe0 = fe_count;
        send_note(8'h90, 8'h3C, 8'h64);
        idle(40);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL note_on_pending: %0d bytes missing, required 0", exp_q.size());
        end
        checks++;
        if (fe_count != fe0) begin
            errors++;
            $display("FAIL note_on_frameerr: got %0d pulses, required 0", fe_count - fe0);
        end
    endtask

    task automatic test_running_status();
        send_note(8'h80, 8'h3C, 8'h00);
        send_byte(8'h3E);
        send_frame(8'h10, 1'b1, 3, 8'h80, 8'h3E);
        idle(40);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL running_status_pending: %0d bytes missing, required 0", exp_q.size());
        end
    endtask

    task automatic test_filtering();
        logic [7:0] junk [9];
        junk = '{8'hB0, 8'h07, 8'h7F, 8'hF0, 8'h7E, 8'h01, 8'hF7, 8'h3C, 8'h40};
        foreach (junk[i]) send_byte(junk[i]);
        send_byte(8'h91);
        send_byte(8'hF8);
        send_byte(8'h40);
        send_byte(8'hFE);
        send_frame(8'h50, 1'b1, 3, 8'h91, 8'h40);
        idle(40);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL filtering_pending: %0d bytes missing, required 0", exp_q.size());
        end
    endtask

    task automatic test_frame_error();
        int fe0 = fe_count;
        send_byte(8'h90);
        send_byte(8'h3C);
        send_frame(8'h55, 1'b0, 0, 8'h00, 8'h00);
        idle(100);
        rx_i = 1'b1;
        idle(40);
        send_byte(8'h3C);
        send_frame(8'h64, 1'b1, 3, 8'h90, 8'h3C);
        idle(40);
        checks++;
        if (fe_count - fe0 != 1) begin
            errors++;
            $display("FAIL frame_err_count: got %0d pulses, required 1", fe_count - fe0);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL frame_err_pending: %0d bytes missing, required 0", exp_q.size());
        end
    endtask

    task automatic test_glitch();
        int fe0 = fe_count;
        @(negedge clk_i);
        rx_i = 1'b0;
        idle(10);
        rx_i = 1'b1;
        idle(400);
        checks++;
        if (fe_count != fe0) begin
            errors++;
            $display("FAIL glitch_frameerr: got %0d pulses, required 0", fe_count - fe0);
        end
        send_note(8'h92, 8'h45, 8'h33);
        idle(40);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL glitch_pending: %0d bytes missing, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        // Reset while the velocity frame is still on the line.
        send_byte(8'h90);
        send_byte(8'h3C);
        @(negedge clk_i);
        rx_i = 1'b0;
        idle(150);
        nrst_i = 1'b0;
        #1;
        checks++;
        if (midiByteValid_o !== 1'b0 || midiByte_o !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_frame: got valid=%b byte=%02h, required 0/00",
                     midiByteValid_o, midiByte_o);
        end
        idle(3);
        rx_i = 1'b1;
        nrst_i = 1'b1;
        idle(400);

        // Reset during the second burst cycle: only the status byte gets out.
        send_byte(8'h90);
        send_byte(8'h3C);
        fork
            send_frame(8'h64, 1'b1, 1, 8'h90, 8'h3C);
            begin
                while (!midiByteValid_o && n < 400) begin
                    @(negedge clk_i);
                    n++;
                end
                checks++;
                if (n >= 400) begin
                    errors++;
                    $display("FAIL reset_burst_timeout: no burst within %0d cycles, required one", n);
                end else begin
                    @(posedge clk_i);
                    #2;
                    nrst_i = 1'b0;
                    #1;
                    checks++;
                    if (midiByteValid_o !== 1'b0 || midiByte_o !== 8'h00) begin
                        errors++;
                        $display("FAIL reset_mid_burst: got valid=%b byte=%02h, required 0/00",
                                 midiByteValid_o, midiByte_o);
                    end
                end
            end
        join
        idle(5);
        nrst_i = 1'b1;
        idle(10);
        // Running status was cleared, so these data bytes produce nothing.
        send_byte(8'h3C);
        send_byte(8'h40);
        idle(40);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL reset_pending: %0d bytes missing, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_note_on();
        test_running_status();
        test_filtering();
        test_frame_error();
        test_glitch();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog");
    end

endmodule
